// File: rtl/exe_cmd_cov_monitor.sv
// exe_cmd_cov_monitor: saturating coverage bins for EXE_CMD and forwarding selects,
// with illegal-command capture, coverage goal flag and a 1-cycle read port.
module exe_cmd_cov_monitor #(
    parameter int CMD_LEN = 4,
    parameter int FSEL_LEN = 2,
    parameter int CNT_W = 16,
    parameter logic [2**CMD_LEN-1:0] LEGAL_MASK = 16'h03FF,
    parameter int GOAL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [CMD_LEN-1:0]  exe_cmd,
    input  logic [FSEL_LEN-1:0] val1_sel,
    input  logic [FSEL_LEN-1:0] val2_sel,
    input  logic [FSEL_LEN-1:0] st_val_sel,
    input  logic                clear,
    input  logic                rd_en,
    input  logic [CMD_LEN+1:0]  rd_addr,
    output logic [CNT_W-1:0]    rd_data,
    output logic                rd_valid,
    output logic                illegal_seen,
    output logic [CMD_LEN-1:0]  illegal_cmd,
    output logic                sat_seen,
    output logic [CMD_LEN:0]    bins_hit,
    output logic                cov_done
);
    localparam int NCMD = 2**CMD_LEN;
    localparam int NFS = 2**FSEL_LEN;
    localparam logic [CNT_W-1:0] MAX = '1;

    if (FSEL_LEN > 2) begin : g_fsel_chk
        $error("exe_cmd_cov_monitor: FSEL_LEN must be <= 2 to fit the read map");
    end

    logic [CNT_W-1:0]    cmd_cnt_q [NCMD];
    logic [CNT_W-1:0]    cmd_cnt_d [NCMD];
    logic [CNT_W-1:0]    fwd_cnt_q [3][NFS];
    logic [CNT_W-1:0]    fwd_cnt_d [3][NFS];
    logic [FSEL_LEN-1:0] sel [3];
    logic [CNT_W-1:0]    rd_word;
    logic [CNT_W-1:0]    rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                illegal_seen_q, illegal_seen_d;
    logic [CMD_LEN-1:0]  illegal_cmd_q, illegal_cmd_d;
    logic                sat_seen_q, sat_seen_d;
    logic [CMD_LEN:0]    bins_hit_q, bins_hit_d;
    logic                cov_done_q, cov_done_d;

    assign sel = '{val1_sel, val2_sel, st_val_sel};

    always_comb begin
        rd_word = '0;
        if (int'(rd_addr) < NCMD) rd_word = cmd_cnt_q[rd_addr[CMD_LEN-1:0]];
        for (int s = 0; s < 3; s++)
            for (int v = 0; v < NFS; v++)
                if (int'(rd_addr) == NCMD + 4*s + v) rd_word = fwd_cnt_q[s][v];
    end

    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        fwd_cnt_d = fwd_cnt_q;
        sat_seen_d = sat_seen_q;
        illegal_seen_d = illegal_seen_q;
        illegal_cmd_d = illegal_cmd_q;
        bins_hit_d = bins_hit_q;
        rd_valid_d = rd_en;
        rd_data_d = rd_en ? rd_word : rd_data_q;
        if (sample_en) begin
            if (cmd_cnt_q[exe_cmd] == MAX) sat_seen_d = 1'b1;
            else cmd_cnt_d[exe_cmd] = cmd_cnt_q[exe_cmd] + CNT_W'(1);
            for (int s = 0; s < 3; s++) begin
                if (fwd_cnt_q[s][sel[s]] == MAX) sat_seen_d = 1'b1;
                else fwd_cnt_d[s][sel[s]] = fwd_cnt_q[s][sel[s]] + CNT_W'(1);
            end
            if (LEGAL_MASK[exe_cmd] && cmd_cnt_q[exe_cmd] == '0) bins_hit_d = bins_hit_q + (CMD_LEN+1)'(1);
            if (!LEGAL_MASK[exe_cmd] && !illegal_seen_q) begin
                illegal_seen_d = 1'b1;
                illegal_cmd_d = exe_cmd;
            end
        end
        // goal is judged on the post-update counts so it rises with the completing sample
        cov_done_d = 1'b1;
        for (int i = 0; i < NCMD; i++)
            if (LEGAL_MASK[i] && cmd_cnt_d[i] < CNT_W'(GOAL)) cov_done_d = 1'b0;
        if (clear) begin
            cmd_cnt_d = '{default: '0};
            fwd_cnt_d = '{default: '{default: '0}};
            sat_seen_d = 1'b0;
            illegal_seen_d = 1'b0;
            illegal_cmd_d = '0;
            bins_hit_d = '0;
            cov_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_cnt_q <= '{default: '0};
            fwd_cnt_q <= '{default: '{default: '0}};
            rd_data_q <= '0;
            rd_valid_q <= 1'b0;
            illegal_seen_q <= 1'b0;
            illegal_cmd_q <= '0;
            sat_seen_q <= 1'b0;
            bins_hit_q <= '0;
            cov_done_q <= 1'b0;
        end else begin
            cmd_cnt_q <= cmd_cnt_d;
            fwd_cnt_q <= fwd_cnt_d;
            rd_data_q <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            illegal_seen_q <= illegal_seen_d;
            illegal_cmd_q <= illegal_cmd_d;
            sat_seen_q <= sat_seen_d;
            bins_hit_q <= bins_hit_d;
            cov_done_q <= cov_done_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign illegal_seen = illegal_seen_q;
    assign illegal_cmd = illegal_cmd_q;
    assign sat_seen = sat_seen_q;
    assign bins_hit = bins_hit_q;
    assign cov_done = cov_done_q;
endmodule

// File: tb/tb_exe_cmd_cov_monitor.sv
// tb_exe_cmd_cov_monitor: table-driven checks of the coverage monitor, plus
// saturation (CNT_W=4), empty legal mask, clear and async reset sequences.
module tb_exe_cmd_cov_monitor;
    logic clk = 0, rst = 1, sample_en = 0, clear = 0, rd_en = 0;
    logic [3:0] exe_cmd = 0;
    logic [1:0] val1_sel = 0, val2_sel = 0, st_val_sel = 0;
    logic [5:0] rd_addr = 0;

    logic [15:0] a_data;
    logic a_valid, a_ill, a_sat, a_cov;
    logic [3:0] a_ill_cmd;
    logic [4:0] a_bins;
    logic [3:0] b_data;
    logic b_valid, b_ill, b_sat, b_cov;
    logic [3:0] b_ill_cmd;
    logic [4:0] b_bins;
    logic [15:0] c_data;
    logic c_valid, c_ill, c_sat, c_cov;
    logic [3:0] c_ill_cmd;
    logic [4:0] c_bins;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    exe_cmd_cov_monitor u_dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .exe_cmd(exe_cmd),
        .val1_sel(val1_sel), .val2_sel(val2_sel), .st_val_sel(st_val_sel),
        .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data),
        .rd_valid(a_valid), .illegal_seen(a_ill), .illegal_cmd(a_ill_cmd),
        .sat_seen(a_sat), .bins_hit(a_bins), .cov_done(a_cov));

    exe_cmd_cov_monitor #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .sample_en(sample_en), .exe_cmd(exe_cmd),
        .val1_sel(val1_sel), .val2_sel(val2_sel), .st_val_sel(st_val_sel),
        .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_data),
        .rd_valid(b_valid), .illegal_seen(b_ill), .illegal_cmd(b_ill_cmd),
        .sat_seen(b_sat), .bins_hit(b_bins), .cov_done(b_cov));

    exe_cmd_cov_monitor #(.LEGAL_MASK(16'h0000)) u_nl (
        .clk(clk), .rst(rst), .sample_en(sample_en), .exe_cmd(exe_cmd),
        .val1_sel(val1_sel), .val2_sel(val2_sel), .st_val_sel(st_val_sel),
        .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(c_data),
        .rd_valid(c_valid), .illegal_seen(c_ill), .illegal_cmd(c_ill_cmd),
        .sat_seen(c_sat), .bins_hit(c_bins), .cov_done(c_cov));

    typedef struct {
        logic samp; logic [3:0] cmd; logic [1:0] s1, s2, s3; logic rd; logic [5:0] addr;
        logic ev; logic [15:0] ed; logic [4:0] eb; logic ec; logic ei; logic [3:0] eic;
    } vec_t;
    vec_t tbl [24];

    function automatic vec_t mk(logic samp, logic [3:0] cmd, logic [1:0] s1, logic [1:0] s2,
                                logic [1:0] s3, logic rd, logic [5:0] addr, logic ev,
                                logic [15:0] ed, logic [4:0] eb, logic ec, logic ei, logic [3:0] eic);
        return '{samp, cmd, s1, s2, s3, rd, addr, ev, ed, eb, ec, ei, eic};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic samp, logic [3:0] cmd, logic clr, logic rd, logic [5:0] addr);
        sample_en = samp; exe_cmd = cmd; clear = clr; rd_en = rd; rd_addr = addr;
        val1_sel = 0; val2_sel = 0; st_val_sel = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 0, 1, 2, 0, 0,  0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 1, 3, 0, 0,  0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 2, 3, 0, 0,  0, 0, 2, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 1, 0,  1, 2, 2, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 1,  1, 1, 2, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 16, 1, 3, 2, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 21, 1, 2, 2, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 1, 22, 1, 1, 2, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 26, 1, 1, 2, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 27, 1, 2, 2, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 28, 1, 0, 2, 0, 0, 0);
        tbl[11] = mk(1, 2, 1, 0, 0, 1, 2,  1, 0, 3, 0, 0, 0);
        tbl[12] = mk(1, 3, 0, 0, 0, 1, 2,  1, 1, 4, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            tbl[13+i] = mk(1, 4'(4+i), 0, 0, 0, 0, 0, 0, 1, 5'(5+i), i == 5, 0, 0);
        tbl[19] = mk(1, 12, 0, 0, 0, 1, 17, 1, 1, 10, 1, 1, 12);
        tbl[20] = mk(1, 14, 0, 0, 0, 1, 12, 1, 1, 10, 1, 1, 12);
        tbl[21] = mk(0, 0, 0, 0, 0, 1, 14, 1, 1, 10, 1, 1, 12);
        tbl[22] = mk(0, 0, 0, 0, 0, 1, 0,  1, 2, 10, 1, 1, 12);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0,  0, 2, 10, 1, 1, 12);

        #3;
        chk("reset rd_valid", a_valid, 0);
        chk("reset rd_data", a_data, 0);
        chk("reset bins_hit", a_bins, 0);
        chk("reset cov_done", a_cov, 0);
        chk("reset empty-mask cov_done", c_cov, 0);
        #9 rst = 0;
        step();
        chk("empty-mask cov_done after reset", c_cov, 1);
        chk("idle bins_hit", a_bins, 0);

        for (int i = 0; i < 24; i++) begin
            sample_en = tbl[i].samp; exe_cmd = tbl[i].cmd; clear = 0;
            val1_sel = tbl[i].s1; val2_sel = tbl[i].s2; st_val_sel = tbl[i].s3;
            rd_en = tbl[i].rd; rd_addr = tbl[i].addr;
            step();
            chk($sformatf("vec%0d rd_valid", i), a_valid, tbl[i].ev);
            chk($sformatf("vec%0d rd_data", i), a_data, tbl[i].ed);
            chk($sformatf("vec%0d bins_hit", i), a_bins, tbl[i].eb);
            chk($sformatf("vec%0d cov_done", i), a_cov, tbl[i].ec);
            chk($sformatf("vec%0d illegal_seen", i), a_ill, tbl[i].ei);
            chk($sformatf("vec%0d illegal_cmd", i), a_ill_cmd, tbl[i].eic);
        end
        chk("no saturation yet", a_sat, 0);
        chk("empty-mask illegal_seen", c_ill, 1);
        chk("empty-mask illegal_cmd", c_ill_cmd, 0);

        drive(1, 0, 1, 1, 0);
        step();
        chk("clear read pre-clear value", a_data, 2);
        chk("clear rd_valid", a_valid, 1);
        chk("clear bins_hit", a_bins, 0);
        chk("clear cov_done", a_cov, 0);
        chk("clear illegal_seen", a_ill, 0);
        chk("clear illegal_cmd", a_ill_cmd, 0);
        chk("clear empty-mask cov_done", c_cov, 0);
        drive(0, 0, 0, 1, 0);
        step();
        chk("clear dropped sample", a_data, 0);
        drive(0, 0, 0, 1, 16);
        step();
        chk("clear fwd bin", a_data, 0);

        for (int i = 0; i < 20; i++) begin
            drive(1, 3, 0, 0, 0);
            step();
            if (i == 14) chk("sat_seen before max hit", b_sat, 0);
            if (i == 15) chk("sat_seen at max hit", b_sat, 1);
        end
        drive(0, 0, 0, 1, 3);
        step();
        chk("saturated cmd bin", b_data, 15);
        chk("wide cmd bin", a_data, 20);
        chk("wide sat_seen", a_sat, 0);
        chk("bins_hit after cmd3", a_bins, 1);
        drive(0, 0, 0, 1, 16);
        step();
        chk("saturated fwd bin", b_data, 15);

        drive(1, 3, 0, 1, 3);
        step();
        chk("pre-reset rd_valid", a_valid, 1);
        #2 rst = 1;
        #1;
        chk("async rst rd_valid", a_valid, 0);
        chk("async rst rd_data", a_data, 0);
        chk("async rst bins_hit", a_bins, 0);
        chk("async rst sat_seen", b_sat, 0);
        chk("async rst sat rd_data", b_data, 0);
        #1 rst = 0;
        drive(0, 0, 0, 1, 40);
        step();
        chk("unmapped rd_valid", a_valid, 1);
        chk("unmapped rd_data", a_data, 0);
        drive(0, 0, 0, 1, 3);
        step();
        chk("post-reset cmd bin", a_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
